life_window: RTL and testbench
==============================

# life_window

Streaming 3x3 neighbourhood generator for the Game-of-Life datapath. It accepts one frame of cell states in raster order over a valid/ready stream. For every cell it emits that cell's own state plus its eight neighbour bits, in exactly the form the per-cell rule evaluator consumes (`self`, `neighbors[7:0]`). Cells outside the grid are dead (0).

## Interface
- `WIDTH`, default 16: grid columns; must be ≥ 2.
- `HEIGHT`, default 16: grid rows; must be ≥ 2.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_cell` is valid.
- `in_ready` output 1: block accepts `in_cell` this cycle.
- `in_cell` input 1: cell state, raster order (row 0, col 0 first).
- `out_valid` output 1: output payload is valid.
- `out_ready` input 1: downstream accepts the payload.
- `out_self` output 1: state of the emitted cell.
- `out_neighbors` output 8: neighbour bits, ordered [0]=NW, [1]=N, [2]=NE, [3]=W, [4]=E, [5]=SW, [6]=S, [7]=SE.
- `out_last` output 1: payload is cell (HEIGHT-1, WIDTH-1).

## Operation
- Internal virtual scan over a padded grid: rows r = 0..HEIGHT, columns c = 0..WIDTH. Each step consumes one position.
  - Positions with r < HEIGHT and c < WIDTH take a real input cell.
  - All other positions inject 0 without consuming input.
- State machine `LOAD` / `EDGE` / `DRAIN`:
  - `LOAD` (r < HEIGHT, c < WIDTH): consumes input. Leaves for `EDGE` after c = WIDTH-1.
  - `EDGE` (c = WIDTH, r < HEIGHT): injects 0, then goes to `LOAD` at c = 0, r+1. When r+1 = HEIGHT it goes to `DRAIN` instead.
  - `DRAIN` (r = HEIGHT): injects 0 for c = 0..WIDTH. After c = WIDTH, goes to `LOAD` r = 0, c = 0 (next frame).
- Storage:
  - Two line buffers of WIDTH bits hold rows r-1 and r-2.
  - A 3x3 window register holds columns c-2..c; each step shifts in new column {line2[c], line1[c], new}.
  - Column c = WIDTH reads 0 from both line buffers.
  - At c = 0 the left and middle window columns are cleared before the shift (west border).
  - Both line buffers are cleared on the final `DRAIN` step, so row -1 of the next frame reads 0 and nothing carries over between frames.
- Emission: a step at (r, c) with r ≥ 1 and c ≥ 1 emits cell (r-1, c-1), giving HEIGHT×WIDTH outputs per frame.
  - `out_self` is the window centre.
  - `out_neighbors` holds the other eight window bits in the order above.
  - `out_last` = 1 for the step at (HEIGHT, WIDTH).
- Handshake:
  - Step enable = (!out_valid || out_ready) && (state != `LOAD` || in_valid).
  - `in_ready` = (state == `LOAD`) && (!out_valid || out_ready). It is combinational from `out_ready`.
  - Non-emitting steps (c = 0 or r = 0) do not require output space but still obey the same enable, for simplicity.
- Output payload is registered. It holds stable while out_valid && !out_ready. out_valid drops after acceptance unless a new emitting step fires in the same cycle.

## Timing
- Reset values:
  - Outputs: `out_valid`=0, `out_self`=0, `out_neighbors`=0, `out_last`=0.
  - Internal: state `LOAD`, r=c=0, line buffers and window all 0.
- Immediately after reset `in_ready`=1.
- Latency: the payload for cell (r, c) appears one cycle after the step at (r+1, c+1).
  - Cell (0,0) follows acceptance of input (1,1), i.e. input number WIDTH+2.
- Throughput: (HEIGHT+1)×(WIDTH+1) step cycles per frame with no stalls.
  - `in_ready` is low during `EDGE` (1 cycle per row) and during `DRAIN` (WIDTH+1 cycles).
- Simultaneous out_ready acceptance and a new emitting step: the payload is replaced with no bubble.
- Reset mid-frame: all state returns to reset values next edge. The partial frame is discarded and the next input is treated as cell (0,0).

## Structure
- Shared `life_pkg` holds:
  - The neighbour index constants (NW..SE = 0..7), shared with the rule evaluator.
  - The state enum `LOAD`/`EDGE`/`DRAIN`.
- One natural sub-module, `life_linebuf`: a WIDTH-bit shift/row store with synchronous clear. It is instantiated twice.

## Test plan
- Reset, then idle (`in_valid`=0): `out_valid`=0, `in_ready`=1, and no state advances.
- WIDTH=HEIGHT=4, single live cell at (1,1), out_ready=1, 16 outputs expected:
  - Cell (1,1): self=1, neighbors=0x00.
  - (0,0)=0x80, (0,1)=0x40, (0,2)=0x20, (1,0)=0x10, (1,2)=0x08, (2,0)=0x04, (2,1)=0x02, (2,2)=0x01.
  - All other cells: 0x00.
- 4x4 all-ones frame:
  - Corners: (0,0)=0xD0, (0,3)=0x68, (3,0)=0x16, (3,3)=0x0B.
  - Interior cells: 0xFF.
  - `out_last`=1 only on (3,3).
- Random out_ready (50%) with random in_valid: exactly 16 outputs in raster order, no loss or duplication, payload stable while stalled.
- All-ones frame followed immediately by an all-zero frame: every second-frame output is self=0, neighbors=0x00.
- Reset asserted mid-frame after 7 inputs, then a full all-ones frame: outputs match the clean all-ones case exactly.

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life datapath: neighbour bit positions
// (also used by the rule evaluator) and the scan state encoding.
package life_pkg;

    // Neighbour bit positions inside the 8-bit neighbour vector.
    localparam int NB_NW = 0;
    localparam int NB_N  = 1;
    localparam int NB_NE = 2;
    localparam int NB_W  = 3;
    localparam int NB_E  = 4;
    localparam int NB_SW = 5;
    localparam int NB_S  = 6;
    localparam int NB_SE = 7;

    // Virtual scan over the padded grid: real cells, east pad column, south pad row.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        EDGE  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/life_linebuf.sv
// One grid row of cell history as a WIDTH-bit shift register. A bit shifted
// in at column c reappears at dout exactly WIDTH shifts later, i.e. at the
// same column of the next row.
module life_linebuf #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [WIDTH-1:0] row_q;

    assign dout = row_q[WIDTH-1];

    // Shift one cell per enabled step; clear wipes the whole row at frame end.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the row store is reset like any other state; it is only WIDTH flops and a known-zero row -1 depends on it.
        if (rst) begin
            row_q <= '0;
        end else if (clr) begin
            row_q <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of statement order.
            row_q <= {row_q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/life_window.sv
// Streaming 3x3 neighbourhood generator. Scans a grid padded with one dead
// column on the east and one dead row on the south, so every real cell is
// emitted once its full neighbourhood has been seen.
module life_window
    import life_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_cell,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_self,
    output logic [7:0] out_neighbors,
    output logic       out_last
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam logic [CW-1:0] COL_PAD  = CW'(WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_PAD  = RW'(HEIGHT);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    scan_state_t   state, state_next;
    logic [CW-1:0] col, col_next;
    logic [RW-1:0] row, row_next;

    logic step, emit, new_bit, keep_left;
    logic line_en, line_clr, line1_q, line2_q, up1, up2;

    // Window columns: [0] = c-2 (west), [1] = c-1 (centre), [2] = c (east).
    // Rows: top = r-2, mid = r-1, bot = r. The window doubles as the output
    // payload register: it moves only on a step, and no step can fire while
    // a payload is stalled.
    logic [2:0] win_top, win_mid, win_bot;

    assign step      = (!out_valid || out_ready) && (state != LOAD || in_valid);
    assign in_ready  = (state == LOAD) && (!out_valid || out_ready);
    assign emit      = step && (row != '0) && (col != '0);
    assign new_bit   = (state == LOAD) && in_cell;
    assign keep_left = (col != '0);

    // The pad column reads dead cells from both row stores.
    assign line_en  = step && (col != COL_PAD);
    assign line_clr = step && (state == DRAIN) && (col == COL_PAD);
    assign up1      = (col != COL_PAD) && line1_q;
    assign up2      = (col != COL_PAD) && line2_q;

    life_linebuf #(.WIDTH(WIDTH)) u_line1 (
        .clk  (clk),
        .rst  (rst),
        .en   (line_en),
        .clr  (line_clr),
        .din  (new_bit),
        .dout (line1_q)
    );

    life_linebuf #(.WIDTH(WIDTH)) u_line2 (
        .clk  (clk),
        .rst  (rst),
        .en   (line_en),
        .clr  (line_clr),
        .din  (line1_q),
        .dout (line2_q)
    );

    // Scan position and state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
            col   <= col_next;
        end
    end

    // Next scan position: walk the (HEIGHT+1) x (WIDTH+1) padded grid.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        row_next   = row;
        col_next   = col;
        if (step) begin
            unique case (state)
                LOAD: begin
                    if (col == COL_LAST) begin
                        col_next   = COL_PAD;
                        state_next = EDGE;
                    end else begin
                        col_next = col + 1'b1;
                    end
                end
                EDGE: begin
                    col_next = '0;
                    if (row == ROW_LAST) begin
                        row_next   = ROW_PAD;
                        state_next = DRAIN;
                    end else begin
                        row_next   = row + 1'b1;
                        state_next = LOAD;
                    end
                end
                DRAIN: begin
                    if (col == COL_PAD) begin
                        col_next   = '0;
                        row_next   = '0;
                        state_next = LOAD;
                    end else begin
                        col_next = col + 1'b1;
                    end
                end
                default: state_next = LOAD;
            endcase
        end
    end

    // Shift a new column into the window; at column 0 the west side is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_top <= '0;
            win_mid <= '0;
            win_bot <= '0;
        end else if (step) begin
            win_top <= {up2,     win_top[2], win_top[1] & keep_left};
            win_mid <= {up1,     win_mid[2], win_mid[1] & keep_left};
            win_bot <= {new_bit, win_bot[2], win_bot[1] & keep_left};
        end
    end

    // Output valid and last-cell flag follow the emitting steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= (row == ROW_PAD) && (col == COL_PAD);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_self = win_mid[1];

    // Map the eight non-centre window bits onto the evaluator's neighbour order.
    always_comb begin
        out_neighbors        = '0;
        out_neighbors[NB_NW] = win_top[0];
        out_neighbors[NB_N]  = win_top[1];
        out_neighbors[NB_NE] = win_top[2];
        out_neighbors[NB_W]  = win_mid[0];
        out_neighbors[NB_E]  = win_mid[2];
        out_neighbors[NB_SW] = win_bot[0];
        out_neighbors[NB_S]  = win_bot[1];
        out_neighbors[NB_SE] = win_bot[2];
    end

endmodule

// File: tb/tb_life_window.sv
// Bench for life_window on a 4x4 grid: fixed vectors from hand-worked
// neighbourhoods plus streamed frames checked against a grid-level model.
module tb_life_window;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;
    localparam int BUDGET = 2000;

    typedef logic [N-1:0] frame_t;

    typedef struct packed {
        logic       self_bit;
        logic [7:0] nbrs;
        logic       last;
    } payload_t;

    typedef struct {
        string      name;
        int         which;
        int         row;
        int         col;
        logic       self_bit;
        logic [7:0] nbrs;
        logic       last;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_cell = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_self;
    logic [7:0] out_neighbors;
    logic       out_last;

    int n_cmp = 0;
    int n_bad = 0;

    bit       in_q[$];
    payload_t exp_q[$];
    payload_t got[$];
    vec_t     vecs[$];

    always #5 clk = ~clk;

    life_window #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cell       (in_cell),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_self      (out_self),
        .out_neighbors (out_neighbors),
        .out_last      (out_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Grid-level reference: look up the eight neighbours directly, dead outside.
    function automatic payload_t ref_cell(input frame_t fr, input int r, input int c);
        int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int rr;
        int cc;
        payload_t p;
        p.self_bit = fr[r*W + c];
        p.last     = (r == H-1) && (c == W-1);
        for (int k = 0; k < 8; k++) begin
            rr = r + dr[k];
            cc = c + dc[k];
            p.nbrs[k] = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? fr[rr*W + cc] : 1'b0;
        end
        return p;
    endfunction

    task automatic queue_frame(input frame_t fr);
        for (int i = 0; i < N; i++) begin
            in_q.push_back(fr[i]);
            exp_q.push_back(ref_cell(fr, i / W, i % W));
        end
    endtask

    // Stream queued inputs and score every accepted output, one decision per cycle.
    task automatic run(input int v_pct, input int r_pct, input bit chk_lat, input string tag);
        int       cyc = 0;
        int       fed = 0;
        int       nout = 0;
        bit       seen_valid = 1'b0;
        bit       stalled = 1'b0;
        payload_t held = '0;
        payload_t cur;
        payload_t e;
        got.delete();
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < BUDGET) begin
            @(negedge clk);
            cur = {out_self, out_neighbors, out_last};
            if (stalled) check({tag, " stall-hold"}, cur, held);
            if (chk_lat && out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                check({tag, " first-output latency"}, fed, W + 2);
            end
            in_valid  = (in_q.size() > 0) && ($urandom_range(99) < v_pct);
            in_cell   = in_valid ? in_q[0] : 1'($urandom_range(1));
            out_ready = ($urandom_range(99) < r_pct);
            #1;
            if (in_valid && in_ready) begin
                void'(in_q.pop_front());
                fed++;
            end
            if (out_valid && out_ready) begin
                got.push_back(cur);
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected extra output"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s out%0d", tag, nout), cur, e);
                end
                nout++;
            end
            stalled = out_valid && !out_ready;
            held    = cur;
            cyc++;
        end
        check({tag, " items left at end"}, in_q.size() + exp_q.size(), 0);
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic add_vec(input string name, input int which, input int r, input int c,
                           input logic s, input logic [7:0] nb, input logic l);
        vec_t v;
        v.name = name; v.which = which; v.row = r; v.col = c;
        v.self_bit = s; v.nbrs = nb; v.last = l;
        vecs.push_back(v);
    endtask

    task automatic apply_table(input int which);
        payload_t act;
        int idx;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].which == which) begin
                idx = vecs[i].row * W + vecs[i].col;
                act = (idx < got.size()) ? got[idx] : 'x;
                check(vecs[i].name, act, {vecs[i].self_bit, vecs[i].nbrs, vecs[i].last});
            end
        end
    endtask

    initial begin
        frame_t single;
        frame_t ones;
        int fed;
        int cyc;

        single = '0;
        single[1*W + 1] = 1'b1;
        ones = '1;

        // Hand-worked vectors: 0 = single live cell at (1,1), 1 = all ones.
        add_vec("single c11", 0, 1, 1, 1'b1, 8'h00, 1'b0);
        add_vec("single c00", 0, 0, 0, 1'b0, 8'h80, 1'b0);
        add_vec("single c01", 0, 0, 1, 1'b0, 8'h40, 1'b0);
        add_vec("single c02", 0, 0, 2, 1'b0, 8'h20, 1'b0);
        add_vec("single c10", 0, 1, 0, 1'b0, 8'h10, 1'b0);
        add_vec("single c12", 0, 1, 2, 1'b0, 8'h08, 1'b0);
        add_vec("single c20", 0, 2, 0, 1'b0, 8'h04, 1'b0);
        add_vec("single c21", 0, 2, 1, 1'b0, 8'h02, 1'b0);
        add_vec("single c22", 0, 2, 2, 1'b0, 8'h01, 1'b0);
        add_vec("single c03", 0, 0, 3, 1'b0, 8'h00, 1'b0);
        add_vec("single c33", 0, 3, 3, 1'b0, 8'h00, 1'b1);
        add_vec("ones c00",   1, 0, 0, 1'b1, 8'hD0, 1'b0);
        add_vec("ones c03",   1, 0, 3, 1'b1, 8'h68, 1'b0);
        add_vec("ones c30",   1, 3, 0, 1'b1, 8'h16, 1'b0);
        add_vec("ones c33",   1, 3, 3, 1'b1, 8'h0B, 1'b1);
        add_vec("ones c11",   1, 1, 1, 1'b1, 8'hFF, 1'b0);
        add_vec("ones c22",   1, 2, 2, 1'b1, 8'hFF, 1'b0);
        add_vec("ones c32",   1, 3, 2, 1'b1, 8'h1F, 1'b0);

        // Reset values.
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset payload", {out_self, out_neighbors, out_last}, 0);
        rst = 1'b0;

        // Idle: nothing moves without input.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d out_valid", i), out_valid, 0);
            check($sformatf("idle%0d in_ready", i), in_ready, 1);
        end

        queue_frame(single);
        run(100, 100, 1'b1, "single");
        apply_table(0);

        queue_frame(ones);
        run(100, 100, 1'b0, "ones");
        apply_table(1);

        // All-ones immediately followed by all-zeros: nothing leaks across frames.
        queue_frame(ones);
        queue_frame('0);
        run(100, 100, 1'b0, "b2b");

        // Random content with random valid and ready.
        queue_frame(frame_t'({$urandom, $urandom}));
        queue_frame(frame_t'({$urandom, $urandom}));
        run(70, 50, 1'b0, "rand");

        // Reset in the middle of a frame after 7 inputs.
        fed = 0;
        cyc = 0;
        in_cell = 1'b1;
        while (fed < 7 && cyc < 100) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            if (in_ready) fed++;
            cyc++;
        end
        check("partial frame inputs", fed, 7);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset in_ready", in_ready, 1);
        check("midreset payload", {out_self, out_neighbors, out_last}, 0);
        @(negedge clk);
        rst = 1'b0;

        queue_frame(ones);
        run(100, 100, 1'b1, "after-reset");
        apply_table(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
